// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage.
// Forms load data (byte/half extension, LWL/LWR merge) from the raw data-memory
// word, registers it with destination info, and counts retired instructions.
module mem_wb_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic              in_valid,
  input  logic [31:0]       Instr_in,
  input  logic [31:0]       aluResult_in,
  input  logic [31:0]       data_read_in,
  input  logic [31:0]       regB_in,
  input  logic [5:0]        ALU_control_in,
  input  logic              MemRead_in,
  input  logic [4:0]        writeRegister_in,
  input  logic              do_writeback_in,
  output logic [31:0]       writeData1_WB,
  output logic [4:0]        writeRegister1_WB,
  output logic              do_writeback1_WB,
  output logic [31:0]       Instr_WB,
  output logic              misalign_WB,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [5:0] OP_LB  = 6'b100001;
  localparam logic [5:0] OP_LBU = 6'b101010;
  localparam logic [5:0] OP_LH  = 6'b101011;
  localparam logic [5:0] OP_LHU = 6'b101100;
  localparam logic [5:0] OP_LWL = 6'b101101;
  localparam logic [5:0] OP_LWR = 6'b101110;

  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [RW-1:0]    wreg_q, wreg_d;
  logic             dowb_q, dowb_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       k;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [XLEN-1:0]  base;
  logic [XLEN-1:0]  load_data;
  logic             load_mis;

  // Load alignment/extension and LWL/LWR merge, with WB bypass of the merge base
  always_comb begin
    k         = aluResult_in[1:0];
    byte_sel  = data_read_in[31:24];
    half_sel  = data_read_in[31:16];
    load_data = aluResult_in;
    load_mis  = 1'b0;
    base      = regB_in;
    if (dowb_q && (wreg_q == writeRegister_in)) begin
      base = wdata_q;
    end
    case (k)
      2'd0:    byte_sel = data_read_in[31:24];
      2'd1:    byte_sel = data_read_in[23:16];
      2'd2:    byte_sel = data_read_in[15:8];
      default: byte_sel = data_read_in[7:0];
    endcase
    if (k[1]) begin
      half_sel = data_read_in[15:0];
    end
    if (MemRead_in) begin
      case (ALU_control_in)
        OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
        OP_LBU: load_data = {24'h0, byte_sel};
        OP_LH, OP_LHU: begin
          if (k[0]) begin
            load_data = '0;
            load_mis  = 1'b1;
          end else if (ALU_control_in == OP_LH) begin
            load_data = {{16{half_sel[15]}}, half_sel};
          end else begin
            load_data = {16'h0, half_sel};
          end
        end
        OP_LWL: begin
          case (k)
            2'd0:    load_data = data_read_in;
            2'd1:    load_data = {data_read_in[23:0], base[7:0]};
            2'd2:    load_data = {data_read_in[15:0], base[15:0]};
            default: load_data = {data_read_in[7:0], base[23:0]};
          endcase
        end
        OP_LWR: begin
          case (k)
            2'd0:    load_data = {base[31:8], data_read_in[31:24]};
            2'd1:    load_data = {base[31:16], data_read_in[31:16]};
            2'd2:    load_data = {base[31:24], data_read_in[31:8]};
            default: load_data = data_read_in;
          endcase
        end
        default: begin
          load_data = data_read_in;
          load_mis  = (k != 2'd0);
        end
      endcase
    end
  end

  // Stage next-state: FLUSH squashes, STALL holds, otherwise capture
  always_comb begin
    wdata_d = wdata_q;
    wreg_d  = wreg_q;
    dowb_d  = dowb_q;
    instr_d = instr_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    if (FLUSH) begin
      dowb_d = 1'b0;
      mis_d  = 1'b0;
    end else if (!STALL) begin
      wdata_d = load_data;
      wreg_d  = writeRegister_in;
      dowb_d  = in_valid & do_writeback_in & (writeRegister_in != 5'd0);
      instr_d = Instr_in;
      mis_d   = in_valid & MemRead_in & load_mis;
      if (in_valid) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Stage registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wdata_q <= '0;
      wreg_q  <= '0;
      dowb_q  <= 1'b0;
      instr_q <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wdata_q <= wdata_d;
      wreg_q  <= wreg_d;
      dowb_q  <= dowb_d;
      instr_q <= instr_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign writeData1_WB     = wdata_q;
  assign writeRegister1_WB = wreg_q;
  assign do_writeback1_WB  = dowb_q;
  assign Instr_WB          = instr_q;
  assign misalign_WB       = mis_q;
  assign retired_cnt       = cnt_q;

endmodule
